// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef word_t           instr_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } fetch_state_e;

    function automatic word_t align_word(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, decode-side output and redirect.
interface fetch_unit_if;
    import mips_pkg::*;

    logic   imem_req_valid;
    logic   imem_req_ready;
    word_t  imem_req_addr;
    logic   imem_rsp_valid;
    instr_t imem_rsp_data;
    logic   out_valid;
    logic   out_ready;
    instr_t out_instr;
    word_t  out_pc;
    word_t  out_pc4;
    logic   redirect;
    word_t  redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous circular FIFO with flush; a pop frees room for a same-cycle push when full.
module fetch_queue #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             full, do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CntW'(Depth));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential imem requests, queues responses, flushes on redirect.
module fetch_unit
    import mips_pkg::*;
#(
    parameter word_t       RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CntW = $clog2(QDEPTH + 1);
    localparam int unsigned SumW = CntW + 2;

    word_t           fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    fetch_state_e    state_q, state_d;

    logic            pend_empty, out_empty;
    logic [CntW-1:0] pend_cnt, out_cnt;
    word_t           pend_head;
    logic [2*XLEN-1:0] out_head;

    logic            req_valid, req_fire, rsp_keep, rsp_drop, out_fire;
    logic [SumW-1:0] outstanding, total;

    always_comb begin
        outstanding = SumW'(pend_cnt) + SumW'(drop_cnt_q);
        total       = outstanding + SumW'(out_cnt);
        req_valid   = rst && !bus.redirect && (total < SumW'(QDEPTH));
        req_fire    = req_valid && bus.imem_req_ready;
        // Stale responses drain first since imem answers strictly in order.
        rsp_keep    = bus.imem_rsp_valid && !bus.redirect && (state_q == StRun) && !pend_empty;
        rsp_drop    = bus.imem_rsp_valid && !bus.redirect && (state_q == StFlush);
        out_fire    = bus.out_valid && bus.out_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;
        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        unique case (state_q)
            StRun:   ;
            StFlush: if (rsp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
            default: ;
        endcase
        if (bus.redirect) begin
            fetch_pc_d = align_word(bus.redirect_pc);
            drop_cnt_d = (bus.imem_rsp_valid && outstanding != '0) ?
                         CntW'(outstanding - SumW'(1)) : CntW'(outstanding);
        end
        state_d = (drop_cnt_d != '0) ? StFlush : StRun;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            state_q    <= StRun;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    fetch_queue #(
        .Width (XLEN),
        .Depth (QDEPTH)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .head      (pend_head),
        .empty     (pend_empty),
        .count     (pend_cnt)
    );

    fetch_queue #(
        .Width (2 * XLEN),
        .Depth (QDEPTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (rsp_keep),
        .push_data ({pend_head, bus.imem_rsp_data}),
        .pop       (out_fire),
        .head      (out_head),
        .empty     (out_empty),
        .count     (out_cnt)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = rst ? fetch_pc_q : RESET_PC;
    assign bus.out_valid      = rst && !out_empty;
    assign bus.out_pc         = out_head[2*XLEN-1:XLEN];
    assign bus.out_instr      = out_head[XLEN-1:0];
    assign bus.out_pc4        = bus.out_pc + XLEN'(4);

    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, number of output-queue entries; it is also the maximum count of in-flight imem requests.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; in order, one per accepted request, latency >=1 cycle.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-010 SHALL have port out_valid  output  1  instruction available to decode/execute.
REQ-011 SHALL have port out_ready  input  1  consumer accepts instruction.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  32  address of out_instr.
REQ-014 SHALL have port out_pc4  output  32  out_pc + 4, modulo 2^32.
REQ-015 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-016 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 00.

Function
REQ-017 fetch_pc register SHALL advance by 4 (wrapping 32'hFFFF_FFFC -> 32'h0000_0000) on every cycle with imem_req_valid && imem_req_ready.
REQ-018 imem_req_valid SHALL assert only when occupancy + inflight (including responses pending drop) < QDEPTH and redirect is low; out_ready SHALL NOT combinationally affect imem_req_valid.
REQ-019 Once asserted, imem_req_valid and imem_req_addr SHALL hold stable until accepted, except withdrawal in a redirect cycle.
REQ-020 Each accepted address SHALL be recorded in an internal pending FIFO; on imem_rsp_valid the head address and imem_rsp_data SHALL be pushed to the output queue, visible on out_* the next cycle.
REQ-021 out_valid SHALL equal output queue non-empty; out_instr/out_pc/out_pc4 SHALL reflect the head entry; entry pops on out_valid && out_ready.
REQ-022 Simultaneous push and pop SHALL be supported at any occupancy, including full, with no loss and no duplication.
REQ-023 On redirect: fetch_pc <= {redirect_pc[31:2],2'b00}; output queue and pending FIFO cleared; drop_cnt <= responses outstanding (not arriving in that cycle); no request issued that cycle.
REQ-024 A response arriving in the redirect cycle, or while drop_cnt > 0, SHALL be discarded, decrementing drop_cnt in the latter case.
REQ-025 An out handshake coinciding with redirect SHALL complete; the entry is not re-presented.
REQ-026 New requests SHALL issue from the cycle after redirect even while drop_cnt > 0; in-order responses guarantee stale ones arrive first.
REQ-027 A second redirect while drop_cnt > 0 SHALL add any newly accepted outstanding requests to drop_cnt.
REQ-028 FSM states: RUN (normal), FLUSH (drop_cnt > 0); RUN->FLUSH on redirect with outstanding > 0; FLUSH->RUN when drop_cnt reaches 0 with no redirect.
REQ-029 imem_rsp_valid with zero outstanding SHALL be ignored and flagged by a simulation assertion.

Reset
REQ-030 While rst is low: fetch_pc = RESET_PC, imem_req_valid = 0, out_valid = 0, queues empty, drop_cnt = 0, state RUN; imem_req_addr = RESET_PC.
REQ-031 Reset mid-operation SHALL discard all in-flight state; responses arriving during reset or after its release for pre-reset requests are not required to be handled (memory is reset together).
REQ-032 First request SHALL be presented the cycle after rst rises.

Structure
REQ-033 Shared package mips_pkg SHALL hold XLEN = 32, the default RESET_PC value and the instruction-word type; fetch_unit imports it.
REQ-034 One sub-module, fetch_queue (parameterised width/depth synchronous FIFO with flush), SHALL implement both pending FIFO and output queue.

Verification
REQ-035 Reset release, imem ready always, latency 1, out_ready=1 -> out_pc sequence 0x0,0x4,0x8..., out_pc4 = out_pc+4.
REQ-036 out_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid low after 2 issues, no drop or duplicate on resume.
REQ-037 Two requests outstanding (0x10,0x14), redirect to 0x103 -> both responses discarded, next out_pc = 0x100, out_instr from address 0x100.
REQ-038 fetch_pc = 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000; out_pc4 = 0x0000_0000 for the first.
REQ-039 imem_req_ready low 3 cycles -> imem_req_addr stable at 0x8 throughout, fetch_pc advances once on acceptance.
REQ-040 rst asserted mid-stream with full queue -> next cycle out_valid=0, imem_req_valid=0; after release first out_pc = RESET_PC.
